// File: rtl/lfm_pkg.sv
// Shared constants and FSM state type for the linear-FM phase generator.
package lfm_pkg;

    localparam int PHASE_W = 16;
    localparam int FRAC_W  = 16;
    localparam int LEN_W   = 24;
    localparam int NSW_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfm_state_e;

endpackage

// File: rtl/lfm_freq_acc.sv
// Fractional frequency-word accumulator: load a start word, or add a signed step.
// Only the integer part (above the fraction bits) leaves this block.
module lfm_freq_acc
    import lfm_pkg::*;
#(
    parameter int P_W   = PHASE_W,
    parameter int F_W   = FRAC_W,
    parameter int ACC_W = P_W + F_W
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load,
    input  logic [ACC_W-1:0] load_val,
    input  logic             en,
    input  logic [ACC_W-1:0] step,
    output logic [P_W-1:0]   phase
);

    logic [ACC_W-1:0] acc;

    // Two's complement step: plain modulo add covers up- and down-chirps.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (en) begin
            acc <= acc + step;
        end
    end

    assign phase = acc[ACC_W-1:F_W];

endmodule

// File: rtl/lfm_phase_gen.sv
// AXI4-Stream chirp phase-increment source for a DDS phase input.
// Define LFM_TLAST_EN to add m_axis_phase_tlast marking the last sample of each sweep.
module lfm_phase_gen #(
    parameter int PHASE_W = lfm_pkg::PHASE_W,
    parameter int FRAC_W  = lfm_pkg::FRAC_W,
    parameter int LEN_W   = lfm_pkg::LEN_W,
    parameter int NSW_W   = lfm_pkg::NSW_W,
    parameter int ACC_W   = PHASE_W + FRAC_W
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic               abort,
    input  logic [ACC_W-1:0]   cfg_start_ftw,
    input  logic [ACC_W-1:0]   cfg_step,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [NSW_W-1:0]   cfg_nsweeps,
    output logic [PHASE_W-1:0] m_axis_phase_tdata,
    output logic               m_axis_phase_tvalid,
    input  logic               m_axis_phase_tready,
`ifdef LFM_TLAST_EN
    output logic               m_axis_phase_tlast,
`endif
    output logic               busy,
    output logic               done
);

    import lfm_pkg::*;

    lfm_state_e       state;
    logic [ACC_W-1:0] start_q;
    logic [ACC_W-1:0] step_q;
    logic [LEN_W-1:0] len_q;
    logic [NSW_W-1:0] nsw_q;
    logic [LEN_W-1:0] samp_cnt;
    logic [NSW_W-1:0] sw_cnt;

    logic             hs;
    logic             start_ok;
    logic             last_samp;
    logic             last_sweep;
    logic             acc_load;
    logic [ACC_W-1:0] acc_load_val;
    logic             acc_en;

    assign hs         = m_axis_phase_tvalid & m_axis_phase_tready;
    assign start_ok   = (state == IDLE) && start && (cfg_len != '0);
    assign last_samp  = (samp_cnt == len_q - LEN_W'(1));
    assign last_sweep = (nsw_q != '0) && (sw_cnt == nsw_q - NSW_W'(1));

    // Each sweep restarts from the latched start word, not from the live cfg.
    assign acc_load     = start_ok | (hs & last_samp);
    assign acc_load_val = (state == IDLE) ? cfg_start_ftw : start_q;
    assign acc_en       = hs & ~last_samp;

    lfm_freq_acc #(
        .P_W   (PHASE_W),
        .F_W   (FRAC_W),
        .ACC_W (ACC_W)
    ) u_acc (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (acc_load),
        .load_val (acc_load_val),
        .en       (acc_en),
        .step     (step_q),
        .phase    (m_axis_phase_tdata)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state               <= IDLE;
            start_q             <= '0;
            step_q              <= '0;
            len_q               <= '0;
            nsw_q               <= '0;
            samp_cnt            <= '0;
            sw_cnt              <= '0;
            m_axis_phase_tvalid <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        start_q             <= cfg_start_ftw;
                        step_q              <= cfg_step;
                        len_q               <= cfg_len;
                        nsw_q               <= cfg_nsweeps;
                        samp_cnt            <= '0;
                        sw_cnt              <= '0;
                        state               <= RUN;
                        m_axis_phase_tvalid <= 1'b1;
                        busy                <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort only acts on a handshake so a presented beat is never withdrawn.
                    if (hs) begin
                        if (last_samp) begin
                            samp_cnt <= '0;
                            if (abort || last_sweep) begin
                                state               <= IDLE;
                                m_axis_phase_tvalid <= 1'b0;
                                busy                <= 1'b0;
                                done                <= 1'b1;
                            end else if (sw_cnt != '1) begin
                                sw_cnt <= sw_cnt + NSW_W'(1);
                            end
                        end else begin
                            samp_cnt <= samp_cnt + LEN_W'(1);
                            if (abort) begin
                                state               <= IDLE;
                                m_axis_phase_tvalid <= 1'b0;
                                busy                <= 1'b0;
                                done                <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state               <= IDLE;
                    m_axis_phase_tvalid <= 1'b0;
                    busy                <= 1'b0;
                end
            endcase
        end
    end

`ifdef LFM_TLAST_EN
    assign m_axis_phase_tlast = m_axis_phase_tvalid & last_samp;
`endif

endmodule

// File: tb/tb_lfm_phase_gen.sv
// Self-checking bench for lfm_phase_gen: vector table plus scoreboard of expected beats.
module tb_lfm_phase_gen;

    localparam int PHASE_W = 16;
    localparam int FRAC_W  = 16;
    localparam int ACC_W   = PHASE_W + FRAC_W;
    localparam int LEN_W   = 24;
    localparam int NSW_W   = 16;

    logic               aclk;
    logic               aresetn;
    logic               start;
    logic               abort;
    logic [ACC_W-1:0]   cfg_start_ftw;
    logic [ACC_W-1:0]   cfg_step;
    logic [LEN_W-1:0]   cfg_len;
    logic [NSW_W-1:0]   cfg_nsweeps;
    logic [PHASE_W-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic               busy;
    logic               done;

    lfm_phase_gen dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .start               (start),
        .abort               (abort),
        .cfg_start_ftw       (cfg_start_ftw),
        .cfg_step            (cfg_step),
        .cfg_len             (cfg_len),
        .cfg_nsweeps         (cfg_nsweeps),
        .m_axis_phase_tdata  (tdata),
        .m_axis_phase_tvalid (tvalid),
        .m_axis_phase_tready (tready),
`ifdef LFM_TLAST_EN
        .m_axis_phase_tlast  (tlast),
`endif
        .busy                (busy),
        .done                (done)
    );

`ifndef LFM_TLAST_EN
    assign tlast = 1'b0;
`endif

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic [31:0]       ftw;
        logic [31:0]       step;
        logic [23:0]       len;
        logic [15:0]       nsw;
        int                n;
        logic [7:0][15:0]  exp;
    } vec_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    beats = 0;
    int    done_cnt = 0;
    int    busy_cyc = 0;
    logic  held_v = 1'b0;
    logic [15:0] held_d = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a beat seen valid&ready at the negedge is accepted at the next posedge.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (done) begin
                done_cnt++;
                chk("done_outputs_idle", {62'd0, busy, tvalid}, 64'd0);
            end
            if (busy) busy_cyc++;
            if (tvalid && held_v) chk("hold_stable", tdata, held_d);
            held_v = tvalid && !tready;
            held_d = tdata;
            if (tvalid && tready) begin
                beats++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_beat: got tdata %0h, expected no beat", tdata);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("tdata", tdata, e.d);
`ifdef LFM_TLAST_EN
                    chk("tlast", tlast, e.l);
`endif
                end
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic push_beat(input logic [15:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        sb.push_back(b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    // Run one programmed chirp to completion; mode 1 toggles tready 1,0,0,...
    task automatic go(input logic [31:0] ftw, input logic [31:0] step, input logic [23:0] len,
                      input logic [15:0] nsw, input int mode, input int n_exp, input int max_cyc,
                      input string name);
        int b0, bc0, d0, cyc;
        b0  = beats;
        bc0 = busy_cyc;
        d0  = done_cnt;
        cfg_start_ftw = ftw;
        cfg_step      = step;
        cfg_len       = len;
        cfg_nsweeps   = nsw;
        tready        = 1'b1;
        pulse_start();
        cyc = 0;
        while (done_cnt == d0 && cyc < max_cyc) begin
            tready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(posedge aclk); #1;
            cyc++;
        end
        if (cyc >= max_cyc) $display("FAIL %s_timeout: got %0d cycles, expected done", name, cyc);
        chk({name, "_done"}, done_cnt - d0, 1);
        chk({name, "_beats"}, beats - b0, n_exp);
        chk({name, "_sb_empty"}, sb.size(), 0);
        if (mode == 0) chk({name, "_throughput"}, busy_cyc - bc0, n_exp);
        tready = 1'b1;
        @(posedge aclk); #1;
        chk({name, "_no_extra_done"}, done_cnt - d0, 1);
    endtask

    vec_t vec[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tready = 1'b1;
        cfg_start_ftw = '0;
        cfg_step = '0;
        cfg_len = '0;
        cfg_nsweeps = '0;

        vec[0] = '{32'h0005_0000, 32'h0001_0000, 24'd4, 16'd2, 8,
                   {16'd8, 16'd7, 16'd6, 16'd5, 16'd8, 16'd7, 16'd6, 16'd5}};
        vec[1] = '{32'hFFFF_0000, 32'h0001_0000, 24'd3, 16'd1, 3,
                   {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'h0001, 16'h0000, 16'hFFFF}};
        vec[2] = '{32'h0002_0000, 32'hFFFF_0000, 24'd3, 16'd1, 3,
                   {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2}};
        vec[3] = '{32'h0000_8000, 32'h0000_C000, 24'd4, 16'd1, 4,
                   {16'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd2, 16'd1, 16'd0}};
        vec[4] = vec[0];

        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tlast", tlast, 0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("post_rst_idle", {tvalid, busy, done}, 0);

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < vec[i].n; k++)
                push_beat(vec[i].exp[k], (k % int'(vec[i].len)) == int'(vec[i].len) - 1);
            go(vec[i].ftw, vec[i].step, vec[i].len, vec[i].nsw, (i == 4) ? 1 : 0,
               vec[i].n, 200, $sformatf("vec%0d", i));
        end

        // 0 -> 10 MHz chirp at 100 MHz sample rate
        for (int k = 0; k < 10000; k++) begin
            longint unsigned p;
            p = (longint'(42950) * longint'(k)) >> 16;
            push_beat(p[15:0], k == 9999);
        end
        go(32'd0, 32'd42950, 24'd10000, 16'd1, 0, 10000, 11000, "chirp");

        // Continuous mode, abort while the beat is stalled
        begin
            int b0, d0, cyc;
            for (int k = 0; k < 13; k++) push_beat(16'((k % 5) + 1), (k % 5) == 4);
            b0 = beats;
            d0 = done_cnt;
            cfg_start_ftw = 32'h0001_0000;
            cfg_step      = 32'h0001_0000;
            cfg_len       = 24'd5;
            cfg_nsweeps   = 16'd0;
            tready        = 1'b1;
            pulse_start();
            cyc = 0;
            while (beats - b0 < 12 && cyc < 100) begin
                @(posedge aclk); #1;
                cyc++;
            end
            tready = 1'b0;
            abort  = 1'b1;
            repeat (3) @(posedge aclk);
            #1;
            chk("abort_held_tvalid", tvalid, 1);
            chk("abort_held_busy", busy, 1);
            chk("abort_held_tdata", tdata, 3);
            chk("abort_no_early_done", done_cnt - d0, 0);
            tready = 1'b1;
            cyc = 0;
            while (done_cnt == d0 && cyc < 10) begin
                @(posedge aclk); #1;
                cyc++;
            end
            abort = 1'b0;
            chk("abort_done", done_cnt - d0, 1);
            chk("abort_beats", beats - b0, 13);
            chk("abort_tvalid_low", tvalid, 0);
            chk("abort_sb_empty", sb.size(), 0);
        end

        // start with zero length is ignored
        begin
            int d0;
            d0 = done_cnt;
            cfg_len = '0;
            cfg_nsweeps = 16'd1;
            pulse_start();
            repeat (3) @(posedge aclk);
            #1;
            chk("len0_busy", busy, 0);
            chk("len0_tvalid", tvalid, 0);
            chk("len0_done", done_cnt - d0, 0);
        end

        // Asynchronous reset mid-sweep, then a clean restart
        begin
            int d0;
            for (int k = 0; k < 10; k++) push_beat(16'(k + 3), k == 9);
            d0 = done_cnt;
            cfg_start_ftw = 32'h0003_0000;
            cfg_step      = 32'h0001_0000;
            cfg_len       = 24'd10;
            cfg_nsweeps   = 16'd1;
            tready        = 1'b1;
            pulse_start();
            repeat (3) @(posedge aclk);
            #3;
            aresetn = 1'b0;
            #1;
            chk("async_rst_tvalid", tvalid, 0);
            chk("async_rst_busy", busy, 0);
            chk("async_rst_tdata", tdata, 0);
            sb.delete();
            repeat (2) @(posedge aclk);
            #1;
            aresetn = 1'b1;
            @(posedge aclk); #1;
            chk("async_rst_no_done", done_cnt - d0, 0);
            for (int k = 0; k < 3; k++) push_beat(16'(k + 3), k == 2);
            go(32'h0003_0000, 32'h0001_0000, 24'd3, 16'd1, 0, 3, 50, "restart");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
